// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the pipeline-register interface.
// Each stage register is driven by an {en, flush} pair; flush only acts together with en.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_HOLD  = '{en: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STAGE_RUN   = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_FLUSH = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard check between the load in EX and the instruction in ID.
// Kept separate so the comparison can be exercised on its own.
module hazard_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_uses_rs1,
    input  logic       ifid_uses_rs2,
    output logic       lu
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load into x0 cannot create a hazard.
    assign rs1_hit = ifid_uses_rs1 && (ifid_rs1 == idex_rd);
    assign rs2_hit = ifid_uses_rs2 && (ifid_rs2 == idex_rd);
    assign lu      = idex_mem_read && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: stage enables/flushes,
// PC enable/redirect, the redirect-during-fetch drain sequence and saturating counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_target,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  pc_redirect_addr,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_t     state;
    ctrl_state_t     next_state;
    logic [XLEN-1:0] drain_target;
    logic            capture_target;
    logic            redirect_taken;
    logic            dstall;
    logic            istall;
    logic            lu;
    stage_ctrl_t     ifid;
    stage_ctrl_t     idex;
    stage_ctrl_t     exmem;
    stage_ctrl_t     memwb;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_uses_rs1 (ifid_uses_rs1),
        .ifid_uses_rs2 (ifid_uses_rs2),
        .lu            (lu)
    );

    assign dstall = dmem_req && !dmem_resp;
    assign istall = imem_req && !imem_resp;

    // Everything below is forced quiet while reset is held, independent of state.
    always_comb begin
        ifid             = STAGE_HOLD;
        idex             = STAGE_HOLD;
        exmem            = STAGE_HOLD;
        memwb            = STAGE_HOLD;
        pc_en            = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = '0;
        next_state       = state;
        capture_target   = 1'b0;
        redirect_taken   = 1'b0;

        if (rst) begin
            unique case (state)
                RUN: begin
                    pc_redirect_addr = ex_target;
                    if (dstall) begin
                        memwb = STAGE_FLUSH;
                    end else if (ex_redirect && !istall) begin
                        pc_en          = 1'b1;
                        pc_redirect    = 1'b1;
                        ifid           = STAGE_FLUSH;
                        idex           = STAGE_FLUSH;
                        exmem          = STAGE_RUN;
                        memwb          = STAGE_RUN;
                        redirect_taken = 1'b1;
                    end else if (ex_redirect) begin
                        // The in-flight wrong-path fetch must land before the PC can move.
                        ifid           = STAGE_FLUSH;
                        idex           = STAGE_FLUSH;
                        exmem          = STAGE_RUN;
                        memwb          = STAGE_RUN;
                        next_state     = DRAIN;
                        capture_target = 1'b1;
                        redirect_taken = 1'b1;
                    end else if (lu) begin
                        idex  = STAGE_FLUSH;
                        exmem = STAGE_RUN;
                        memwb = STAGE_RUN;
                    end else if (istall) begin
                        ifid  = STAGE_FLUSH;
                        idex  = STAGE_RUN;
                        exmem = STAGE_RUN;
                        memwb = STAGE_RUN;
                    end else begin
                        pc_en = 1'b1;
                        ifid  = STAGE_RUN;
                        idex  = STAGE_RUN;
                        exmem = STAGE_RUN;
                        memwb = STAGE_RUN;
                    end
                end

                DRAIN: begin
                    // ID/EX only holds bubbles here, so a new ex_redirect cannot be real.
                    pc_redirect_addr = drain_target;
                    ifid             = STAGE_FLUSH;
                    if (dstall) begin
                        memwb = STAGE_FLUSH;
                    end else begin
                        idex  = STAGE_RUN;
                        exmem = STAGE_RUN;
                        memwb = STAGE_RUN;
                    end
                    if (imem_resp) begin
                        pc_en       = 1'b1;
                        pc_redirect = 1'b1;
                        next_state  = RUN;
                    end
                end

                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    assign ifid_en     = ifid.en;
    assign ifid_flush  = ifid.flush;
    assign idex_en     = idex.en;
    assign idex_flush  = idex.flush;
    assign exmem_en    = exmem.en;
    assign exmem_flush = exmem.flush;
    assign memwb_en    = memwb.en;
    assign memwb_flush = memwb.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            drain_target <= '0;
        end else begin
            state <= next_state;
            if (capture_target) begin
                drain_target <= ex_target;
            end
        end
    end

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect_taken && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard/stall controller for the 5-stage RV32I pipeline.
- Drives the en/flush inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable and redirect, from memory handshakes, load-use detection and EX-stage branch redirects.
- Owns the redirect-during-fetch drain sequence and saturating performance counters.

Parameters:
- CNT_W, 32, width of each saturating performance counter.
- XLEN, 32, address width of the redirect target.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- imem_req  in  1  fetch request outstanding.
- imem_resp  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM-stage load/store outstanding.
- dmem_resp  in  1  data access complete this cycle.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of instruction in EX.
- ifid_rs1, ifid_rs2  in  5 each  source registers of instruction in ID.
- ifid_uses_rs1, ifid_uses_rs2  in  1 each  source register actually read.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- ex_target  in  XLEN  redirect target.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC mux selects pc_redirect_addr.
- pc_redirect_addr  out  XLEN  redirect address (live or latched).
- ifid_en, ifid_flush  out  1 each  IF/ID register control.
- idex_en, idex_flush  out  1 each  ID/EX register control.
- exmem_en, exmem_flush  out  1 each  EX/MEM register control.
- memwb_en, memwb_flush  out  1 each  MEM/WB register control.
- stall_cycles  out  CNT_W  cycles with pc_en=0.
- flush_count  out  CNT_W  redirects taken.

Behaviour:
- Reset (rst=0, async): state=RUN; drain_target=0; counters=0. All en=0, all flush=0, pc_en=0, pc_redirect=0 while reset is asserted.
- Outputs are combinational (Mealy) from state and inputs. Only state, drain_target and the counters are registered.
- A flush is effective only together with its en; every flush is asserted with en=1.
- Conditions:
  - dstall = dmem_req & ~dmem_resp.
  - istall = imem_req & ~imem_resp.
  - lu = idex_mem_read & idex_rd!=0 & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
- State RUN, evaluated in strict priority order:
  1. dstall: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0; memwb_en=1 with memwb_flush=1 (bubble into WB). Any redirect is held by the frozen EX and is serviced later.
  2. ex_redirect & ~istall: pc_en=1, pc_redirect=1, pc_redirect_addr=ex_target; ifid/idex flush; exmem/memwb en; flush_count+1.
  3. ex_redirect & istall: go to DRAIN, drain_target<=ex_target. Flush ifid and idex; pc_en=0; flush_count+1.
  4. lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1; exmem/memwb en.
  5. istall: pc_en=0, ifid_en=1 with ifid_flush=1; all later stages en.
  6. Otherwise: all en=1, no flush, pc_en=1.
- State DRAIN (the wrong-path fetch is in flight):
  - ifid_flush=1 with ifid_en=1 every cycle, discarding the wrong-path fetch including the imem_resp cycle.
  - idex/exmem/memwb en, unless dstall, which freezes them as in RUN.
  - pc_en=0 until imem_resp. On that cycle: pc_en=1, pc_redirect=1, pc_redirect_addr=drain_target, next state RUN.
  - A new ex_redirect in DRAIN is impossible, because ID/EX holds bubbles; it is ignored.
- Counters: stall_cycles increments on every non-reset cycle with pc_en=0. Both counters saturate at all-ones and never wrap.
- Simultaneous dstall and istall: dstall rules apply; IF/ID is frozen rather than flushed.
- Reset mid-DRAIN returns to RUN and discards drain_target.

Decomposition:
- Shared package pipeline_ctrl_pkg: enum ctrl_state_t {RUN, DRAIN}, and struct stage_ctrl_t {en, flush}, reused by the pipeline-register interface.
- One natural sub-module: hazard_detect. It is combinational and computes lu from the ID/EX and IF/ID fields, so the load-use check is unit-testable.

Test Plan:
- Reset release, all inputs 0 → every en=1, pc_en=1, counters 0; during rst=0 all outputs 0.
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1.
- dmem miss: dmem_req=1 for 4 cycles, dmem_resp on the 4th → 3 cycles of frozen front end with memwb_flush=1; 4th cycle all en=1.
- Redirect, no fetch pending: ex_redirect=1, ex_target=0x0000_0100 → pc_redirect=1, addr 0x100, ifid/idex flushed, flush_count=1.
- Redirect during fetch: imem_req=1 with resp 3 cycles later, ex_target=0x200 → DRAIN; ifid_flush held; on the resp cycle pc_redirect=1, addr 0x200; back to RUN.
- Saturation: CNT_W=4, hold dstall 20 cycles → stall_cycles sticks at 15.
